// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one single-cycle ALU among NUM_REQ valid/ready requesters.
// Requests are arbitrated round-robin. Results are captured into a one-entry tagged response register.
// Defining ALU_SHARE_ARB_FIXED_PRIO_EN selects fixed priority (lowest valid index wins) and removes rr_q.
module alu_share_arb #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int NUM_REQ     = 2,
    parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_i,
    input  logic [NUM_REQ*5-1:0]           req_op_i,
    input  logic [NUM_REQ*SHAMT_WIDTH-1:0] req_shamt_i,
    input  logic [NUM_REQ-1:0]             req_invert_i,
    output logic [DATA_WIDTH-1:0]          alu_a_o,
    output logic [DATA_WIDTH-1:0]          alu_b_o,
    output logic [4:0]                     alu_op_o,
    output logic [SHAMT_WIDTH-1:0]         alu_shamt_o,
    output logic                           alu_invert_o,
    input  logic [DATA_WIDTH-1:0]          alu_result_i,
    input  logic [DATA_WIDTH:0]            alu_adder_i,
    input  logic                           alu_comp_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [ID_WIDTH-1:0]            rsp_id_o,
    output logic [DATA_WIDTH-1:0]          rsp_result_o,
    output logic [DATA_WIDTH:0]            rsp_adder_o,
    output logic                           rsp_comp_o
);
    localparam logic [4:0] OP_ADD = 5'd0;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state_q, state_d;
    logic                found, space, grant;
    logic [ID_WIDTH-1:0] g, idx, base;

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [ID_WIDTH-1:0] rr_q;
    assign base = rr_q;
`endif

    // Search from base upward with wrap; the loop runs downward so the nearest valid index is written last
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ID_WIDTH'((int'(base) + i) % NUM_REQ);
            if (req_valid_i[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    assign space       = (state_q == EMPTY) || rsp_ready_i;
    assign grant       = found && space && !rst_i;
    assign req_ready_o = grant ? (NUM_REQ'(1) << g) : '0;
    assign rsp_valid_o = (state_q == FULL);

    // Winner's operands go to the ALU; without a grant the ALU sees a quiet ADD of zeros
    always_comb begin
        alu_a_o      = grant ? req_a_i[g*DATA_WIDTH +: DATA_WIDTH] : '0;
        alu_b_o      = grant ? req_b_i[g*DATA_WIDTH +: DATA_WIDTH] : '0;
        alu_op_o     = grant ? req_op_i[g*5 +: 5] : OP_ADD;
        alu_shamt_o  = grant ? req_shamt_i[g*SHAMT_WIDTH +: SHAMT_WIDTH] : '0;
        alu_invert_o = grant ? req_invert_i[g] : 1'b0;
    end

    // Response slot: refill on grant, otherwise drain when the consumer takes it
    always_comb begin
        state_d = state_q;
        if (grant)
            state_d = FULL;
        else if (rsp_ready_i)
            state_d = EMPTY;
    end

    // State, captured ALU outputs and the round-robin pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
            rsp_adder_o  <= '0;
            rsp_comp_o   <= 1'b0;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
            rr_q         <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (grant) begin
                rsp_id_o     <= g;
                rsp_result_o <= alu_result_i;
                rsp_adder_o  <= alu_adder_i;
                rsp_comp_o   <= alu_comp_i;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
                rr_q         <= (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed scoreboard bench for alu_share_arb with NUM_REQ=2 and NUM_REQ=3 instances
module tb_alu_share_arb;
    localparam int W = 32;

    typedef struct packed {
        logic [2:0]   id;
        logic [W-1:0] res;
        logic [W:0]   add;
        logic         cmp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   e_id;
    exp_t q[$];

    always #5 clk = ~clk;

    logic [1:0]     v2, rdy2, inv2;
    logic [2*W-1:0] a2, b2;
    logic [9:0]     op2, sh2;
    logic           r2, ainv2, cmp2, rcmp2, rv2, rid2;
    logic [W-1:0]   aa2, ab2, res2, rres2;
    logic [4:0]     aop2, ash2;
    logic [W:0]     add2, radd2;

    logic [2:0]     v3, rdy3, inv3;
    logic [3*W-1:0] a3, b3;
    logic [14:0]    op3, sh3;
    logic           r3, ainv3, cmp3, rcmp3, rv3;
    logic [1:0]     rid3;
    logic [W-1:0]   aa3, ab3, res3, rres3;
    logic [4:0]     aop3, ash3;
    logic [W:0]     add3, radd3;

    function automatic logic [W:0] f_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic inv);
        return {1'b0, a} + {1'b0, inv ? ~b : b} + (W+1)'(inv);
    endfunction

    assign add2 = f_add(aa2, ab2, ainv2);
    assign res2 = (aop2 == 5'd0) ? add2[W-1:0] : aa2 ^ ab2;
    assign cmp2 = aa2 < ab2;
    assign add3 = f_add(aa3, ab3, ainv3);
    assign res3 = (aop3 == 5'd0) ? add3[W-1:0] : aa3 ^ ab3;
    assign cmp3 = aa3 < ab3;

    alu_share_arb #(.DATA_WIDTH(W), .SHAMT_WIDTH(5), .NUM_REQ(2)) u2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v2), .req_ready_o(rdy2),
        .req_a_i(a2), .req_b_i(b2), .req_op_i(op2), .req_shamt_i(sh2), .req_invert_i(inv2),
        .alu_a_o(aa2), .alu_b_o(ab2), .alu_op_o(aop2), .alu_shamt_o(ash2), .alu_invert_o(ainv2),
        .alu_result_i(res2), .alu_adder_i(add2), .alu_comp_i(cmp2),
        .rsp_valid_o(rv2), .rsp_ready_i(r2), .rsp_id_o(rid2),
        .rsp_result_o(rres2), .rsp_adder_o(radd2), .rsp_comp_o(rcmp2)
    );

    alu_share_arb #(.DATA_WIDTH(W), .SHAMT_WIDTH(5), .NUM_REQ(3)) u3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_ready_o(rdy3),
        .req_a_i(a3), .req_b_i(b3), .req_op_i(op3), .req_shamt_i(sh3), .req_invert_i(inv3),
        .alu_a_o(aa3), .alu_b_o(ab3), .alu_op_o(aop3), .alu_shamt_o(ash3), .alu_invert_o(ainv3),
        .alu_result_i(res3), .alu_adder_i(add3), .alu_comp_i(cmp3),
        .rsp_valid_o(rv3), .rsp_ready_i(r3), .rsp_id_o(rid3),
        .rsp_result_o(rres3), .rsp_adder_o(radd3), .rsp_comp_o(rcmp3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic inv);
        exp_t e;
        e.id  = 3'(id);
        e.res = inv ? a - b : a + b;
        e.add = f_add(a, b, inv);
        e.cmp = a < b;
        q.push_back(e);
    endtask

    task automatic rsp_chk(input string tag, input logic v, input logic [2:0] id, input logic [W-1:0] res,
                           input logic [W:0] add, input logic cmp, input bit do_pop);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=response expected=empty scoreboard", tag);
            return;
        end
        if (do_pop) e = q.pop_front();
        else e = q[0];
        chk({tag, "_valid"}, v, 1);
        chk({tag, "_id"}, id, e.id);
        chk({tag, "_result"}, res, e.res);
        chk({tag, "_adder"}, add, e.add);
        chk({tag, "_comp"}, cmp, e.cmp);
    endtask

    task automatic set2(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic inv);
        a2[k*W +: W] = a;
        b2[k*W +: W] = b;
        inv2[k] = inv;
    endtask

    task automatic set3(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        a3[k*W +: W] = a;
        b3[k*W +: W] = b;
    endtask

    initial begin
        v2 = '0; a2 = '0; b2 = '0; op2 = '0; sh2 = '0; inv2 = '0; r2 = 1'b1;
        v3 = '0; a3 = '0; b3 = '0; op3 = '0; sh3 = '0; inv3 = '0; r3 = 1'b1;
        rst = 1'b1;
        v2 = 2'b01;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", rdy2, 0);
        chk("rst_valid", rv2, 0);
        chk("rst_result", rres2, 0);
        chk("rst_adder", radd2, 0);
        chk("rst_id", rid2, 0);
        chk("rst_alu_a", aa2, 0);
        chk("rst_valid3", rv3, 0);
        @(negedge clk);
        rst = 1'b0;
        v2 = 2'b00;
        // requester 0: 5 + 3
        set2(0, 5, 3, 0);
        v2 = 2'b01;
        #1;
        chk("t1_ready", rdy2, 2'b01);
        chk("t1_alu_a", aa2, 5);
        chk("t1_alu_b", ab2, 3);
        push(0, 5, 3, 0);
        @(negedge clk);
        v2 = 2'b00;
        #1;
        rsp_chk("t1", rv2, {2'b0, rid2}, rres2, radd2, rcmp2, 1);
        chk("t1_result8", rres2, 8);
        chk("quiet_ready", rdy2, 0);
        chk("quiet_alu_a", aa2, 0);
        chk("quiet_alu_op", aop2, 0);
        chk("quiet_alu_inv", ainv2, 0);
        @(negedge clk);
        #1 chk("t1_drain", rv2, 0);
        // requester 1: 10 - 4 via invert
        set2(1, 10, 4, 1);
        v2 = 2'b10;
        #1;
        chk("t4_ready", rdy2, 2'b10);
        chk("t4_alu_inv", ainv2, 1);
        push(1, 10, 4, 1);
        @(negedge clk);
        v2 = 2'b00;
        inv2 = 2'b00;
        #1;
        rsp_chk("t4", rv2, {2'b0, rid2}, rres2, radd2, rcmp2, 1);
        chk("t4_result6", rres2, 6);
        // both valid continuously
        set2(0, 100, 1, 0);
        set2(1, 200, 2, 0);
        v2 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
            e_id = 0;
`else
            e_id = i % 2;
`endif
            chk($sformatf("arb2_grant%0d", i), rdy2, 1 << e_id);
            push(e_id, e_id == 1 ? 200 : 100, e_id == 1 ? 2 : 1, 0);
            @(negedge clk);
            #1 rsp_chk($sformatf("arb2_rsp%0d", i), rv2, {2'b0, rid2}, rres2, radd2, rcmp2, 1);
        end
        v2 = 2'b00;
        @(negedge clk);
        #1 chk("arb2_drain", rv2, 0);
        // backpressure: hold the response three cycles
        r2 = 1'b0;
        set2(0, 7, 2, 0);
        v2 = 2'b01;
        #1 chk("bp_first_ready", rdy2, 2'b01);
        push(0, 7, 2, 0);
        @(negedge clk);
        set2(1, 9, 1, 0);
        v2 = 2'b10;
        repeat (3) begin
            #1;
            chk("bp_ready", rdy2, 0);
            chk("bp_alu_a", aa2, 0);
            rsp_chk("bp_hold", rv2, {2'b0, rid2}, rres2, radd2, rcmp2, 0);
            @(negedge clk);
        end
        r2 = 1'b1;
        #1;
        chk("bp_release_ready", rdy2, 2'b10);
        chk("bp_release_valid", rv2, 1);
        void'(q.pop_front());
        push(1, 9, 1, 0);
        @(negedge clk);
        v2 = 2'b00;
        #1 rsp_chk("bp_refill", rv2, {2'b0, rid2}, rres2, radd2, rcmp2, 1);
        @(negedge clk);
        #1 chk("bp_drain", rv2, 0);
        // reset while FULL
        r2 = 1'b0;
        set2(0, 1, 1, 0);
        v2 = 2'b01;
        #1 chk("mr_ready", rdy2, 2'b01);
        push(0, 1, 1, 0);
        @(negedge clk);
        #1 rsp_chk("mr_full", rv2, {2'b0, rid2}, rres2, radd2, rcmp2, 1);
        v2 = 2'b11;
        rst = 1'b1;
        #1 chk("mr_rst_ready", rdy2, 0);
        @(negedge clk);
        #1;
        chk("mr_valid", rv2, 0);
        chk("mr_result", rres2, 0);
        rst = 1'b0;
        r2 = 1'b1;
        #1 chk("mr_first_grant", rdy2, 2'b01);
        push(0, 1, 1, 0);
        @(negedge clk);
        v2 = 2'b00;
        #1 rsp_chk("mr_rsp", rv2, {2'b0, rid2}, rres2, radd2, rcmp2, 1);
        @(negedge clk);
        // three requesters, all valid
        for (int k = 0; k < 3; k++) set3(k, 10 * k + 1, k);
        v3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
            e_id = 0;
`else
            e_id = i % 3;
`endif
            chk($sformatf("arb3_grant%0d", i), rdy3, 1 << e_id);
            push(e_id, 10 * e_id + 1, e_id, 0);
            @(negedge clk);
            #1 rsp_chk($sformatf("arb3_rsp%0d", i), rv3, {1'b0, rid3}, rres3, radd3, rcmp3, 1);
        end
        v3 = 3'b000;
        @(negedge clk);
        #1 chk("arb3_drain", rv3, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Arbitrated front end that shares one single-cycle `alu` instance among `NUM_REQ` requesters, e.g. the execute stage, the branch-target unit and the address generator. Each requester uses a valid/ready handshake. The block picks one request per cycle, drives its operands into the ALU, and captures the result into a one-entry response register tagged with the requester index. It sits between the issue logic and the `alu` in the core datapath.

## Interface
- `DATA_WIDTH`, 32, operand and result width; must match the ALU.
- `SHAMT_WIDTH`, 5, shift-amount width; must match the ALU.
- `NUM_REQ`, 2, number of requesters; legal range 2..8.
- `ID_WIDTH`, `$clog2(NUM_REQ)`, width of the requester tag; derived, do not override.
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester accept; at most one bit is high per cycle.
- `req_a_i`  in  NUM_REQ*DATA_WIDTH  operand A; requester k occupies slice k.
- `req_b_i`  in  NUM_REQ*DATA_WIDTH  operand B per requester.
- `req_op_i`  in  NUM_REQ*5  ALU opcode per requester (`core_pkg` encoding).
- `req_shamt_i`  in  NUM_REQ*SHAMT_WIDTH  shift amount per requester.
- `req_invert_i`  in  NUM_REQ  invert (subtract) flag per requester.
- `alu_a_o`, `alu_b_o`  out  DATA_WIDTH  operands driven to the ALU.
- `alu_op_o`  out  5  opcode driven to the ALU.
- `alu_shamt_o`  out  SHAMT_WIDTH  shift amount driven to the ALU.
- `alu_invert_o`  out  1  invert flag driven to the ALU.
- `alu_result_i`  in  DATA_WIDTH  ALU result.
- `alu_adder_i`  in  DATA_WIDTH+1  ALU adder output, including carry.
- `alu_comp_i`  in  1  ALU comparator output.
- `rsp_valid_o`  out  1  response register holds a result.
- `rsp_ready_i`  in  1  consumer accepts the response.
- `rsp_id_o`  out  ID_WIDTH  index of the requester that owns the response.
- `rsp_result_o`  out  DATA_WIDTH  registered ALU result.
- `rsp_adder_o`  out  DATA_WIDTH+1  registered ALU adder output.
- `rsp_comp_o`  out  1  registered ALU comparator output.

## Operation
- Response register FSM has two states, EMPTY and FULL.
  - EMPTY to FULL: a grant occurs.
  - FULL to EMPTY: `rsp_ready_i` is high and there is no grant in the same cycle.
  - FULL to FULL: `rsp_ready_i` is high and a grant occurs (drain and refill in one cycle).
- Grant is permitted when `space = (state == EMPTY) || rsp_ready_i`.
- Grant is blocked while `rst_i` is high.
- Arbitration is round-robin.
  - Pointer `rr_q` marks the highest-priority index.
  - The search runs from `rr_q` upward, wrapping modulo `NUM_REQ`.
  - The first index with `req_valid_i` set wins.
- Arbitration is combinational in the same cycle.
  - `req_ready_o[g]` is high only when `space` is true and `g` is the winner.
  - The winner's operand slices are muxed onto the `alu_*_o` ports.
- On a grant the rising edge captures:
  - `alu_result_i`, `alu_adder_i` and `alu_comp_i` into the response register;
  - `g` into `rsp_id_o`;
  - `rr_q <= (g+1) mod NUM_REQ`.
- With no grant, `rr_q` holds.
- With no grant, the ALU ports are driven quiet: `alu_a_o`, `alu_b_o` and `alu_shamt_o` at 0, `alu_op_o` = ADD, `alu_invert_o` = 0.
- Requester rule: once `req_valid_i[k]` is raised, the requester keeps valid and its payload stable until `req_ready_o[k]` is seen. The block does not check this rule.
- Consumer rule: while `rsp_valid_o` is high and `rsp_ready_i` is low, all `rsp_*` outputs hold stable.

## Timing
- Reset, applied on an edge where `rst_i` is high:
  - `rsp_valid_o` = 0;
  - `rsp_id_o` = 0, `rsp_result_o` = 0, `rsp_adder_o` = 0, `rsp_comp_o` = 0;
  - `rr_q` = 0.
- `req_ready_o` is forced to all zeros combinationally while `rst_i` is high.
- Reset in the middle of operation: a held response is discarded, and no handshake completes in the reset cycle.
- Latency: a request accepted in cycle N produces `rsp_valid_o` = 1 in cycle N+1.
- Throughput: one result per cycle while `rsp_ready_i` stays high.
- Backpressure: while FULL and `rsp_ready_i` = 0, all `req_ready_o` = 0. The ALU ports are then driven quiet.
- Fairness: under full load, each requester is granted at least once every `NUM_REQ` grants.
- Wrap-around: the pointer moves from `NUM_REQ-1` to 0.
- When exactly one requester is valid, it is granted regardless of `rr_q`.

## Configuration
- `ALU_SHARE_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, the lowest valid index wins, and `rr_q` is not implemented.
  - Undefined (default): round-robin as specified above.
  - Latency, handshake and reset behaviour are identical in both modes.

## Test plan
- `NUM_REQ`=2. Requester 0 sends ADD with a=5, b=3; `rsp_ready_i`=1.
  - `req_ready_o`=2'b01 in cycle N.
  - Cycle N+1: `rsp_valid_o`=1, `rsp_result_o`=8, `rsp_id_o`=0.
- Both requesters valid continuously; `rsp_ready_i`=1.
  - Round-robin build: grants alternate 0,1,0,1.
  - Build with the macro: grants are 0,0,0.
- Response held for 3 cycles with `rsp_ready_i`=0.
  - `req_ready_o`=0 throughout and the `rsp_*` outputs are stable.
  - When `rsp_ready_i` rises, a new grant and the drain happen in the same cycle.
- Requester 1 sends ADD with invert=1, a=10, b=4 → `rsp_result_o`=6, `rsp_id_o`=1.
- `NUM_REQ`=3 with all requesters valid; grant order is 0,1,2,0, confirming wrap-around.
- `rst_i` pulsed while FULL.
  - The next cycle shows `rsp_valid_o`=0 and `req_ready_o`=0 during reset.
  - The first grant after reset goes to index 0.
